// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
//   Request/result bundle between the EX-stage control path and the
//   multi-cycle multiply/divide engine.
//
//   Signals driven by the control path (master):
//     start, func, op_a, op_b, flush
//   Signals driven by the engine (slave):
//     stall, busy, done, result_lo, result_hi, div_zero, div_ovf
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;

    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_zero;
    logic             div_ovf;

    modport master (
        output start, func, op_a, op_b, flush,
        input  stall, busy, done, result_lo, result_hi, div_zero, div_ovf
    );

    modport slave (
        input  start, func, op_a, op_b, flush,
        output stall, busy, done, result_lo, result_hi, div_zero, div_ovf
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative signed multiply (radix-2 shift-add) and signed divide
//   (restoring) engine. Operands are reduced to magnitudes on start, the
//   sequence runs one bit per cycle, and a final FIX cycle applies signs and
//   registers the 2*WIDTH result.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-low reset
//     bus    - muldiv_sequencer_if.slave (start/func/op_a/op_b/flush in,
//              stall/busy/done/result_lo/result_hi/div_zero/div_ovf out)
//
//   Timing: start accepted at cycle 0 -> done during cycle WIDTH+2.
//   Divide by zero short-cuts to DONE, so done appears during cycle 1.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic                clk,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);

    localparam logic [3:0]       FUNC_MUL = 4'b0100;
    localparam logic [3:0]       FUNC_DIV = 4'b1000;
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Datapath state. For multiply acc_lo starts as the multiplier and
    // operand holds the multiplicand; for divide acc_lo starts as the
    // dividend (becomes the quotient), acc_hi is the partial remainder and
    // operand holds the divisor.
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, operand_q;
    logic             is_div_q, neg_lo_q, neg_hi_q, ovf_pend_q;
    logic [WIDTH-1:0] result_lo_q, result_hi_q;
    logic             div_zero_q, div_ovf_q;

    // Request decode
    logic             func_mul, func_div, func_valid, b_zero, min_by_neg1;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign func_mul    = (bus.func == FUNC_MUL);
    assign func_div    = (bus.func == FUNC_DIV);
    assign func_valid  = func_mul | func_div;
    assign b_zero      = (bus.op_b == '0);
    assign min_by_neg1 = (bus.op_a == MIN_VAL) && (&bus.op_b);
    assign a_neg       = bus.op_a[WIDTH-1];
    assign b_neg       = bus.op_b[WIDTH-1];
    // |MIN| negates back to MIN, which is the correct unsigned magnitude.
    assign a_mag       = a_neg ? -bus.op_a : bus.op_a;
    assign b_mag       = b_neg ? -bus.op_b : bus.op_b;

    // ---------------------------------------------------------------- FSM
    logic launch, stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = bus.start & func_valid;
                if (bus.start && func_valid && !bus.flush) begin
                    launch  = 1'b1;
                    state_d = (func_div && b_zero) ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (bus.flush)        state_d = IDLE;
                else if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                stall   = 1'b1;
                state_d = bus.flush ? IDLE : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------ iteration step
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_q};
        if (!is_div_q) begin
            // {carry, acc_hi, acc_lo} shifted right by one
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------- sign fix-up
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod = {acc_hi_q, acc_lo_q};
        if (!is_div_q) begin
            if (neg_lo_q) prod = -prod;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else begin
            fix_lo = neg_lo_q ? -acc_lo_q : acc_lo_q;
            fix_hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end
    end

    // ------------------------------------------------------------ datapath
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            operand_q   <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            ovf_pend_q  <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            div_zero_q  <= 1'b0;
            div_ovf_q   <= 1'b0;
        end else if (launch) begin
            cnt_q      <= CNT_W'(WIDTH-1);
            is_div_q   <= func_div;
            neg_lo_q   <= a_neg ^ b_neg;
            neg_hi_q   <= a_neg;
            ovf_pend_q <= func_div & min_by_neg1;
            acc_hi_q   <= '0;
            acc_lo_q   <= func_div ? a_mag : b_mag;
            operand_q  <= func_div ? b_mag : a_mag;
            if (func_div && b_zero) begin
                // Zero divisor goes straight to DONE, so results land now.
                result_lo_q <= '1;
                result_hi_q <= bus.op_a;
                div_zero_q  <= 1'b1;
                div_ovf_q   <= 1'b0;
            end
        end else if (state_q == CALC && !bus.flush) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - 1'b1;
        end else if (state_q == FIX && !bus.flush) begin
            result_lo_q <= fix_lo;
            result_hi_q <= fix_hi;
            div_zero_q  <= 1'b0;
            div_ovf_q   <= ovf_pend_q;
        end
    end

    assign bus.stall     = stall;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result_lo = result_lo_q;
    assign bus.result_hi = result_hi_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.div_ovf   = div_ovf_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed bench for muldiv_sequencer (WIDTH=16). Inputs change 1 time unit
//   after the rising edge; outputs are sampled on the falling edge. Cycle 0 is
//   the cycle in which start is presented to an idle engine.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam logic [3:0] F_MUL = 4'b0100;
    localparam logic [3:0] F_DIV = 4'b1000;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    muldiv_sequencer_if #(.WIDTH(16)) bus ();

    muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation starting now (1 unit after a rising edge, engine
    // idle). Optionally re-asserts start with other operands in inj_cycle.
    // Returns 1 cycle after DONE, i.e. where a back-to-back op may start.
    task automatic run_op(input string tag, input logic [3:0] f,
                          input logic [15:0] a, input logic [15:0] b,
                          input int exp_cycle, input logic [15:0] exp_lo,
                          input logic [15:0] exp_hi, input logic exp_dz,
                          input logic exp_ovf, input int inj_cycle);
        int cyc;
        int stall_low;
        stall_low = 0;
        bus.start = 1'b1;
        bus.func  = f;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        check({tag, "_stall_c0"}, 32'(bus.stall), 32'd1);
        next_cycle();
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 60) begin
            if (cyc == inj_cycle) begin
                bus.start = 1'b1;
                bus.op_a  = 16'd50;
                bus.op_b  = 16'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) break;
            if (!bus.stall) stall_low++;
            next_cycle();
            cyc++;
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cycle));
        check({tag, "_stall_busy"}, 32'(stall_low), 32'd0);
        check({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
        check({tag, "_lo"}, 32'(bus.result_lo), 32'(exp_lo));
        check({tag, "_hi"}, 32'(bus.result_hi), 32'(exp_hi));
        check({tag, "_dz"}, 32'(bus.div_zero), 32'(exp_dz));
        check({tag, "_ovf"}, 32'(bus.div_ovf), 32'(exp_ovf));
        next_cycle();
        bus.start = 1'b0;
    endtask

    initial begin
        int done_seen;
        bus.start = 1'b0;
        bus.func  = 4'b0000;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.flush = 1'b0;
        reset     = 1'b0;
        #12;
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_lo",    32'(bus.result_lo), 32'd0);
        check("rst_hi",    32'(bus.result_hi), 32'd0);
        reset = 1'b1;
        next_cycle();

        // 7 * -3 = -21
        run_op("mul7x-3", F_MUL, 16'd7, 16'hFFFD, 18, 16'hFFEB, 16'hFFFF, 1'b0, 1'b0, -1);
        // 100 / 7, then -100 / 7 back to back
        run_op("div100_7", F_DIV, 16'd100, 16'd7, 18, 16'd14, 16'd2, 1'b0, 1'b0, -1);
        run_op("divm100_7", F_DIV, 16'hFF9C, 16'd7, 18, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, -1);
        // divide by zero shortcut
        run_op("divzero", F_DIV, 16'h1234, 16'h0000, 1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, -1);
        // MIN / -1, then MIN * MIN clears the flag
        run_op("divovf", F_DIV, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0000, 1'b0, 1'b1, -1);
        run_op("mulmin", F_MUL, 16'h8000, 16'h8000, 18, 16'h0000, 16'h4000, 1'b0, 1'b0, -1);

        // Invalid func: no stall, stays idle
        bus.start = 1'b1;
        bus.func  = 4'b0001;
        bus.op_a  = 16'd9;
        bus.op_b  = 16'd9;
        @(negedge clk);
        check("badfunc_stall", 32'(bus.stall), 32'd0);
        next_cycle();
        bus.start = 1'b0;
        @(negedge clk);
        check("badfunc_busy", 32'(bus.busy), 32'd0);
        next_cycle();

        // Flush mul 3*5 in cycle 6
        done_seen = 0;
        bus.start = 1'b1;
        bus.func  = F_MUL;
        bus.op_a  = 16'd3;
        bus.op_b  = 16'd5;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            bus.start = 1'b0;
            bus.flush = (c == 6);
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("flush_busy",  32'(bus.busy), 32'd0);
        check("flush_stall", 32'(bus.stall), 32'd0);
        next_cycle();
        bus.flush = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
            next_cycle();
        end
        check("flush_nodone", 32'(done_seen), 32'd0);
        check("flush_keep_lo", 32'(bus.result_lo), 32'h0000);
        check("flush_keep_hi", 32'(bus.result_hi), 32'h4000);
        run_op("mul3x5", F_MUL, 16'd3, 16'd5, 18, 16'd15, 16'd0, 1'b0, 1'b0, -1);

        // start while busy is ignored: 1000/7 = 142 r 6
        run_op("div_ign", F_DIV, 16'd1000, 16'd7, 18, 16'd142, 16'd6, 1'b0, 1'b0, 3);

        // Asynchronous reset mid-operation (cycle 10)
        bus.start = 1'b1;
        bus.func  = F_DIV;
        bus.op_a  = 16'd1000;
        bus.op_b  = 16'd7;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("arst_busy",  32'(bus.busy), 32'd0);
        check("arst_stall", 32'(bus.stall), 32'd0);
        check("arst_done",  32'(bus.done), 32'd0);
        check("arst_res",   {bus.result_hi, bus.result_lo}, 32'd0);
        check("arst_flags", {30'd0, bus.div_zero, bus.div_ovf}, 32'd0);
        #2;
        reset = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("arst_quiet", 32'(done_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
